button_ctrl: RTL and testbench

- Conditions the raw start/pause push-button before it reaches timer_control.
- Synchronises and debounces the pin, then classifies each press as a short tap or a long hold.
- A short tap toggles a run/pause level. A long hold issues a one-cycle clear request and forces pause.
- Runs on the 100 MHz system clock, with no clock enable.

---
 rtl/button_ctrl.sv | 166 ++++++++++++++++
 tb/tb_button_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
// Start/pause push-button conditioner: polarity correction, 2-flop synchroniser,
// debounce, and tap/hold classification into run/pause toggling and a clear request.
module button_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 200_000_000,
  parameter bit ACTIVE_HIGH       = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic run
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_LONG     = 2'd2
  } state_e;

  logic              pin_s;
  logic [1:0]        sync_q;
  logic              s_s;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              level_q, level_d;
  logic              rise_s, fall_s;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              run_q, run_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  // Normalise the pin so that 1 always means "pressed".
  always_comb begin
    if (ACTIVE_HIGH) begin
      pin_s = btn_raw;
    end else begin
      pin_s = ~btn_raw;
    end
  end

  // Two-flop synchroniser; resets to the not-pressed level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pin_s};
    end
  end

  assign s_s = sync_q[1];

  // Debounce: count cycles of disagreement, flip the level after a full stable run.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    if (s_s == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Debounced level edges, aligned with the edge on which btn_level itself changes.
  always_comb begin
    rise_s = level_d & ~level_q;
    fall_s = ~level_d & level_q;
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
    end
  end

  // Press classifier next state: a release before the hold limit is a tap,
  // reaching the limit first is a long hold; a release coinciding with the limit is a tap.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    run_d      = run_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (rise_s) begin
          state_d    = ST_PRESSED;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end else begin
          state_d = ST_RELEASED;
        end
      end
      ST_PRESSED: begin
        if (fall_s) begin
          state_d   = ST_RELEASED;
          release_d = 1'b1;
          run_d     = ~run_q;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
          run_d   = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_LONG: begin
        if (fall_s) begin
          state_d   = ST_RELEASED;
          release_d = 1'b1;
        end else begin
          state_d = ST_LONG;
        end
      end
      default: begin
        state_d    = ST_RELEASED;
        hold_cnt_d = '0;
        run_d      = 1'b0;
      end
    endcase
  end

  // Classifier state, hold counter and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_RELEASED;
      hold_cnt_q <= '0;
      run_q      <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      run_q      <= run_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign run           = run_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl with a cycle-level behavioural reference model.
module tb_button_ctrl;

  localparam int DB = 4;
  localparam int LP = 20;

  logic clk     = 1'b0;
  logic rstn    = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse, run;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: expected outputs after each clock edge.
  logic m_level = 1'b0, m_press = 1'b0, m_release = 1'b0, m_long = 1'b0;
  logic m_run = 1'b0, m_long_done = 1'b0;
  int   m_edge = 0, m_press_edge = 0;
  logic pin_hist[$];
  logic s_hist[$];

  logic [4:0] dut_v, mdl_v;
  assign dut_v = {btn_level, press_pulse, release_pulse, long_pulse, run};
  assign mdl_v = {m_level, m_press, m_release, m_long, m_run};

  button_ctrl #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP),
    .ACTIVE_HIGH      (1'b1)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .run          (run)
  );

  always #5 clk = ~clk;

  // Model: the pin is seen two edges late; the level flips once DB consecutive
  // samples disagree with it; a press is long once it has lasted LP edges.
  initial begin : model
    logic s_now;
    logic flip;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        pin_hist.delete();
        s_hist.delete();
        m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
        m_run = 1'b0; m_long_done = 1'b0;
      end else begin
        m_edge++;
        pin_hist.push_back(btn_raw);
        s_now = (pin_hist.size() >= 3) ? pin_hist[pin_hist.size() - 3] : 1'b0;
        if (pin_hist.size() > 4) void'(pin_hist.pop_front());
        s_hist.push_back(s_now);
        if (s_hist.size() > DB) void'(s_hist.pop_front());
        flip = (s_hist.size() == DB);
        foreach (s_hist[k]) if (s_hist[k] == m_level) flip = 1'b0;
        m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
        if (flip) begin
          m_level = ~m_level;
          if (m_level) begin
            m_press = 1'b1;
            m_press_edge = m_edge;
            m_long_done = 1'b0;
          end else begin
            m_release = 1'b1;
            if (!m_long_done) m_run = ~m_run;
          end
        end else if (m_level && !m_long_done && (m_edge - m_press_edge == LP)) begin
          m_long = 1'b1;
          m_long_done = 1'b1;
          m_run = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    int np = 0;
    rstn = 1'b0;
    btn_raw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_v !== 5'b00000) $display("FAIL reset_outputs: got %b want %b", dut_v, 5'b00000);
      else n_pass++;
    end
    rstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_v !== mdl_v) $display("FAIL idle cyc %0d: dut %b model %b", i, dut_v, mdl_v);
      else n_pass++;
      if (press_pulse || release_pulse || long_pulse) np++;
    end
    n_checks++;
    if (np !== 0) $display("FAIL idle_pulses: got %0d want 0", np);
    else n_pass++;
  endtask

  task automatic test_tap(input logic exp_run, input string nm);
    int np = 0, nr = 0, rise_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_v !== mdl_v) $display("FAIL %s cyc %0d: dut %b model %b", nm, i, dut_v, mdl_v);
      else n_pass++;
      if (press_pulse === 1'b1) begin
        np++;
        if (rise_at < 0) rise_at = i;
      end
      if (release_pulse === 1'b1) nr++;
      btn_raw = (i < 12) ? 1'b1 : 1'b0;
    end
    n_checks++;
    if (np !== 1) $display("FAIL %s_press_count: got %0d want 1", nm, np); else n_pass++;
    n_checks++;
    if (nr !== 1) $display("FAIL %s_release_count: got %0d want 1", nm, nr); else n_pass++;
    n_checks++;
    if (rise_at < DB + 2 || rise_at > DB + 3)
      $display("FAIL %s_latency: got %0d want %0d..%0d", nm, rise_at, DB + 2, DB + 3);
    else n_pass++;
    n_checks++;
    if (run !== exp_run) $display("FAIL %s_run: got %b want %b", nm, run, exp_run); else n_pass++;
  endtask

  task automatic test_bounce();
    int np = 0, nhi = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_v !== mdl_v) $display("FAIL bounce cyc %0d: dut %b model %b", i, dut_v, mdl_v);
      else n_pass++;
      if (press_pulse || release_pulse || long_pulse) np++;
      if (btn_level === 1'b1) nhi++;
      if (i < 30)      btn_raw = (((i / 2) % 2) == 0) ? 1'b1 : 1'b0;
      else if (i < 40) btn_raw = 1'b0;
      else if (i < 60) btn_raw = (((i - 40) % 4) != 3) ? 1'b1 : 1'b0;
      else             btn_raw = 1'b0;
    end
    n_checks++;
    if (np !== 0) $display("FAIL bounce_pulses: got %0d want 0", np); else n_pass++;
    n_checks++;
    if (nhi !== 0) $display("FAIL bounce_level: high for %0d cycles want 0", nhi); else n_pass++;
  endtask

  task automatic test_long_hold();
    int nl = 0, nr = 0, press_at = -1, long_at = -1;
    logic run_at_long = 1'b1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_v !== mdl_v) $display("FAIL long cyc %0d: dut %b model %b", i, dut_v, mdl_v);
      else n_pass++;
      if (press_pulse === 1'b1) press_at = i;
      if (long_pulse === 1'b1) begin
        nl++;
        long_at = i;
        run_at_long = run;
      end
      if (release_pulse === 1'b1) nr++;
      btn_raw = (i < 60) ? 1'b1 : 1'b0;
    end
    n_checks++;
    if (nl !== 1) $display("FAIL long_count: got %0d want 1", nl); else n_pass++;
    n_checks++;
    if (long_at - press_at !== LP) $display("FAIL long_delay: got %0d want %0d", long_at - press_at, LP);
    else n_pass++;
    n_checks++;
    if (run_at_long !== 1'b0) $display("FAIL long_run_drop: got %b want 0", run_at_long); else n_pass++;
    n_checks++;
    if (nr !== 1) $display("FAIL long_release_count: got %0d want 1", nr); else n_pass++;
    n_checks++;
    if (run !== 1'b0) $display("FAIL long_run_after: got %b want 0", run); else n_pass++;
  endtask

  task automatic test_edge(input int hold_len, input int exp_long, input logic exp_run, input string nm);
    int nl = 0, nr = 0, press_at = -1, rel_at = -1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_v !== mdl_v) $display("FAIL %s cyc %0d: dut %b model %b", nm, i, dut_v, mdl_v);
      else n_pass++;
      if (press_pulse === 1'b1) press_at = i;
      if (long_pulse === 1'b1) nl++;
      if (release_pulse === 1'b1) begin
        nr++;
        rel_at = i;
      end
      btn_raw = (i < hold_len) ? 1'b1 : 1'b0;
    end
    n_checks++;
    if (nl !== exp_long) $display("FAIL %s_long_count: got %0d want %0d", nm, nl, exp_long); else n_pass++;
    n_checks++;
    if (nr !== 1) $display("FAIL %s_release_count: got %0d want 1", nm, nr); else n_pass++;
    n_checks++;
    if (rel_at - press_at !== hold_len) $display("FAIL %s_release_at: got %0d want %0d", nm, rel_at - press_at, hold_len);
    else n_pass++;
    n_checks++;
    if (run !== exp_run) $display("FAIL %s_run: got %b want %b", nm, run, exp_run); else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    int np = 0, rise_at = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_v !== mdl_v) $display("FAIL midrst_pre cyc %0d: dut %b model %b", i, dut_v, mdl_v);
      else n_pass++;
      btn_raw = 1'b1;
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (dut_v !== 5'b00000) $display("FAIL midrst_async: got %b want %b", dut_v, 5'b00000); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_v !== 5'b00000) $display("FAIL midrst_held: got %b want %b", dut_v, 5'b00000); else n_pass++;
    end
    rstn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_v !== mdl_v) $display("FAIL midrst_post cyc %0d: dut %b model %b", i, dut_v, mdl_v);
      else n_pass++;
      if (press_pulse === 1'b1) begin
        np++;
        if (rise_at < 0) rise_at = i + 1;
      end
      btn_raw = (i < 15) ? 1'b1 : 1'b0;
    end
    n_checks++;
    if (np !== 1) $display("FAIL midrst_press_count: got %0d want 1", np); else n_pass++;
    n_checks++;
    if (rise_at !== DB + 2) $display("FAIL midrst_latency: got %0d want %0d", rise_at, DB + 2); else n_pass++;
  endtask

  task automatic test_random();
    logic val;
    int   len;
    for (int seg = 0; seg < 40; seg++) begin
      val = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      len = $urandom_range(1, 3 * DB + LP);
      for (int j = 0; j < len; j++) begin
        @(negedge clk);
        n_checks++;
        if (dut_v !== mdl_v) $display("FAIL random seg %0d cyc %0d: dut %b model %b", seg, j, dut_v, mdl_v);
        else n_pass++;
        btn_raw = val;
      end
    end
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      n_checks++;
      if (dut_v !== mdl_v) $display("FAIL random_tail cyc %0d: dut %b model %b", j, dut_v, mdl_v);
      else n_pass++;
      btn_raw = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_tap(1'b1, "tap1");
    test_tap(1'b0, "tap2");
    test_bounce();
    test_tap(1'b1, "tap3");
    test_long_hold();
    test_edge(LP, 0, 1'b1, "edge_release_wins");
    test_edge(LP + 1, 1, 1'b0, "edge_long_wins");
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
